pc_attack_engine: RTL and testbench

//  Executes the computer's turn of the battleship game: the responder to the game FSM's PC_TURN state.

---
 rtl/pc_attack_engine_pkg.sv | 36 +++
 rtl/pc_attack_engine_if.sv | 29 ++
 rtl/pc_attack_engine_lfsr8.sv | 28 ++
 rtl/pc_attack_engine.sv | 149 ++++++++++++++
 tb/tb_pc_attack_engine.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_attack_engine_pkg.sv
// Shared battleship types: cell encoding, computer-turn FSM states, board geometry.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package battleship_pkg;

   localparam int GRID   = 5;
   localparam int CELLS  = GRID * GRID;
   localparam int ADDR_W = $clog2(CELLS);
   localparam int CNT_W  = 5;

   localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(CELLS);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      SHIP  = 2'b01,
      HIT   = 2'b10,
      MISS  = 2'b11
   } cell_t;

   typedef enum logic [2:0] {
      IDLE,
      PICK,
      READ,
      CHECK,
      WRITE,
      DONE,
      WAIT
   } pc_state_t;

   // Fold the 5 low LFSR bits (0..31) onto the 25 board cells.
   function automatic logic [ADDR_W-1:0] lfsr_to_cell(input logic [ADDR_W-1:0] raw);
      return (raw >= CELLS_A) ? (raw - CELLS_A) : raw;
   endfunction

endpackage

// File: rtl/pc_attack_engine_if.sv
// Bundle between game FSM / player-board RAM (master) and the attack engine (slave).
// Latency: n/a (wires only).
// Backpressure: none; the turn is held by pc_turn_State until pc_move closes it.
interface pc_attack_engine_if;
   import battleship_pkg::*;

   logic              pc_turn_State;
   logic              init;
   logic [CNT_W-1:0]  ship_cells;
   logic [ADDR_W-1:0] board_addr;
   logic [1:0]        board_rdata;
   logic              board_we;
   logic [1:0]        board_wdata;
   logic              pc_move;
   logic              hit;
   logic              no_target;
   logic [CNT_W-1:0]  player_ships;

   modport master (
      output pc_turn_State, init, ship_cells, board_rdata,
      input  board_addr, board_we, board_wdata, pc_move, hit, no_target, player_ships
   );

   modport slave (
      input  pc_turn_State, init, ship_cells, board_rdata,
      output board_addr, board_we, board_wdata, pc_move, hit, no_target, player_ships
   );

endinterface

// File: rtl/pc_attack_engine_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, reset to SEED.
// Latency: new value every clock.
// Backpressure: none; never stalls.
module lfsr8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] q
);

   logic [7:0] q_d;
   logic [7:0] q_q;

   // Shift left, feedback from taps 8,6,5,4 enters bit 0.
   always_comb begin
      q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
   end

   // State register; SEED must be nonzero or the sequence locks up.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q_q <= SEED;
      else      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/pc_attack_engine.sv
// Computer's battleship turn: pick random unattacked cell, read board, write HIT/MISS, pulse pc_move.
// Latency: pc_move 4 cycles after pc_turn_State is sampled for a free cell, +2 per occupied cell skipped.
// Backpressure: dropping pc_turn_State before WRITE aborts silently; WRITE and DONE always finish.
module pc_attack_engine
   import battleship_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input logic               clk,
   input logic               rst,
   pc_attack_engine_if.slave bus
);

   logic [7:0] lfsr;
   logic       lfsr_unused;

   lfsr8 #(.SEED(SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr)
   );

   // Only the low bits form the candidate cell.
   assign lfsr_unused = ^lfsr[7:ADDR_W];

   pc_state_t         state_d, state_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [ADDR_W-1:0] scan_cnt_d, scan_cnt_q;
   logic              board_we_d, board_we_q;
   logic [1:0]        board_wdata_d, board_wdata_q;
   logic              pc_move_d, pc_move_q;
   logic              hit_d, hit_q;
   logic              no_target_d, no_target_q;
   logic [CNT_W-1:0]  player_ships_d, player_ships_q;

   // Next-state and registered-output logic for the whole turn.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      scan_cnt_d     = scan_cnt_q;
      board_we_d     = 1'b0;
      board_wdata_d  = board_wdata_q;
      pc_move_d      = 1'b0;
      hit_d          = 1'b0;
      no_target_d    = 1'b0;
      player_ships_d = player_ships_q;

      case (state_q)
         IDLE: begin
            if (bus.pc_turn_State) state_d = PICK;
         end
         PICK: begin
            if (!bus.pc_turn_State) begin
               state_d = IDLE;
            end else begin
               addr_d     = lfsr_to_cell(lfsr[ADDR_W-1:0]);
               scan_cnt_d = '0;
               state_d    = READ;
            end
         end
         READ: begin
            // board_addr already shows addr_q; RAM data arrives next cycle.
            state_d = bus.pc_turn_State ? CHECK : IDLE;
         end
         CHECK: begin
            if (!bus.pc_turn_State) begin
               state_d = IDLE;
            end else begin
               case (cell_t'(bus.board_rdata))
                  EMPTY: begin
                     board_wdata_d = MISS;
                     board_we_d    = 1'b1;
                     state_d       = WRITE;
                  end
                  SHIP: begin
                     board_wdata_d = HIT;
                     board_we_d    = 1'b1;
                     state_d       = WRITE;
                  end
                  default: begin
                     // Already attacked: step to the next cell, give up after a full sweep.
                     if (scan_cnt_q == LAST_CELL) begin
                        pc_move_d   = 1'b1;
                        no_target_d = 1'b1;
                        state_d     = DONE;
                     end else begin
                        addr_d     = (addr_q == LAST_CELL) ? '0 : addr_q + ADDR_W'(1);
                        scan_cnt_d = scan_cnt_q + ADDR_W'(1);
                        state_d    = READ;
                     end
                  end
               endcase
            end
         end
         WRITE: begin
            pc_move_d = 1'b1;
            hit_d     = (board_wdata_q == HIT);
            if ((board_wdata_q == HIT) && (player_ships_q != '0))
               player_ships_d = player_ships_q - CNT_W'(1);
            state_d = DONE;
         end
         DONE: begin
            state_d = WAIT;
         end
         WAIT: begin
            // One move per turn: rearm only once the game FSM leaves PC_TURN.
            if (!bus.pc_turn_State) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // New game overrides any decrement in the same cycle.
      if (bus.init) player_ships_d = bus.ship_cells;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         scan_cnt_q     <= '0;
         board_we_q     <= 1'b0;
         board_wdata_q  <= 2'b00;
         pc_move_q      <= 1'b0;
         hit_q          <= 1'b0;
         no_target_q    <= 1'b0;
         player_ships_q <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         scan_cnt_q     <= scan_cnt_d;
         board_we_q     <= board_we_d;
         board_wdata_q  <= board_wdata_d;
         pc_move_q      <= pc_move_d;
         hit_q          <= hit_d;
         no_target_q    <= no_target_d;
         player_ships_q <= player_ships_d;
      end
   end

   assign bus.board_addr   = addr_q;
   assign bus.board_we     = board_we_q;
   assign bus.board_wdata  = board_wdata_q;
   assign bus.pc_move      = pc_move_q;
   assign bus.hit          = hit_q;
   assign bus.no_target    = no_target_q;
   assign bus.player_ships = player_ships_q;

endmodule

// File: tb/tb_pc_attack_engine.sv
// Directed bench for pc_attack_engine: behavioural player-board RAM, reference LFSR, vector table.
// Latency: edges counted from the edge that first samples pc_turn_State=1 (edge 0).
// Backpressure: pc_turn_State held 20 cycles past pc_move to prove one move per turn.
module tb_pc_attack_engine;
   import battleship_pkg::*;

   logic clk;
   logic rst;
   pc_attack_engine_if bif ();

   pc_attack_engine #(.SEED(8'hA5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR and board RAM.
   logic [7:0] tb_lfsr;
   logic [1:0] mem [CELLS];
   logic [1:0] mem_init [CELLS];
   logic       load_req;

   function automatic logic [7:0] next_l(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic int cand_of(input logic [7:0] l);
      int c;
      c = int'(l) % 32;
      if (c >= 25) c = c - 25;
      return c;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) tb_lfsr <= 8'hA5;
      else      tb_lfsr <= next_l(tb_lfsr);
   end

   always @(posedge clk) begin
      if (load_req) mem <= mem_init;
      else if (bif.board_we) mem[bif.board_addr] <= bif.board_wdata;
      bif.board_rdata <= mem[bif.board_addr];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   typedef struct {
      int do_init;
      int init_val;
      int want;        // required candidate, -1 = any
      int pre_n;       // attacked cells starting at candidate
      int tgt;         // contents of first free cell
      int init_at_we;  // pulse init on the edge that decrements
      int we_init_val;
      int exp_we;      // -1 = no write
      int exp_wdata;
      int exp_mv;
      int exp_hit;
      int exp_nt;
      int exp_ships;
   } vec_t;

   vec_t vecs [9];

   task automatic wait_cand(input int want, output int c);
      int k;
      k = 0;
      while (want >= 0 && cand_of(next_l(tb_lfsr)) != want && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (want >= 0) chk("wait_cand", cand_of(next_l(tb_lfsr)), want);
      c = cand_of(next_l(tb_lfsr));
   endtask

   task automatic preset(input int c, input int pre_n, input int tgt);
      for (int i = 0; i < CELLS; i++) mem_init[i] = 2'b00;
      for (int i = 0; i < pre_n && i < CELLS; i++)
         mem_init[(c + i) % CELLS] = (i % 2 == 1) ? 2'b11 : 2'b10;
      if (pre_n < CELLS) mem_init[(c + pre_n) % CELLS] = 2'(tgt);
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int c, we_n, mv_n, we_edge, mv_edge, we_addr, we_data, mv_hit, mv_nt, after;
      if (v.do_init != 0) begin
         bif.ship_cells = 5'(v.init_val);
         bif.init = 1'b1;
         @(negedge clk);
         bif.init = 1'b0;
      end
      wait_cand(v.want, c);
      preset(c, v.pre_n, v.tgt);
      load_req = 1'b1;
      bif.pc_turn_State = 1'b1;
      we_n = 0; mv_n = 0; we_edge = -1; mv_edge = -1;
      we_addr = -1; we_data = -1; mv_hit = -1; mv_nt = -1; after = 0;
      for (int k = 0; k < 200 && after < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         load_req = 1'b0;
         bif.init = 1'b0;
         if (mv_edge >= 0) after++;
         if (bif.board_we) begin
            we_n++;
            if (we_edge < 0) begin
               we_edge = k; we_addr = int'(bif.board_addr); we_data = int'(bif.board_wdata);
               if (v.init_at_we != 0) begin
                  bif.ship_cells = 5'(v.we_init_val);
                  bif.init = 1'b1;
               end
            end
         end
         if (bif.pc_move) begin
            mv_n++;
            if (mv_edge < 0) begin
               mv_edge = k; mv_hit = int'(bif.hit); mv_nt = int'(bif.no_target);
            end
         end
      end
      bif.pc_turn_State = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("v%0d we_edge", id), we_edge, v.exp_we);
      chk($sformatf("v%0d we_count", id), we_n, (v.exp_we >= 0) ? 1 : 0);
      if (v.exp_we >= 0) begin
         chk($sformatf("v%0d we_addr", id), we_addr, (c + v.pre_n) % CELLS);
         chk($sformatf("v%0d wdata", id), we_data, v.exp_wdata);
      end
      chk($sformatf("v%0d move_edge", id), mv_edge, v.exp_mv);
      chk($sformatf("v%0d move_count", id), mv_n, 1);
      chk($sformatf("v%0d hit", id), mv_hit, v.exp_hit);
      chk($sformatf("v%0d no_target", id), mv_nt, v.exp_nt);
      chk($sformatf("v%0d player_ships", id), int'(bif.player_ships), v.exp_ships);
   endtask

   initial begin
      int c, k, seen, cnt;
      vec_t tail;

      //          init val want pre tgt  iaw wiv  we  wdat mv  hit nt ships
      vecs[0] = '{1,   3,  -1,  0,  1,   0,  0,   3,  2,   4,  1,  0, 2};
      vecs[1] = '{0,   0,  -1,  0,  0,   0,  0,   3,  3,   4,  0,  0, 2};
      vecs[2] = '{0,   0,  24,  2,  0,   0,  0,   7,  3,   8,  0,  0, 2};
      vecs[3] = '{0,   0,  -1,  1,  1,   0,  0,   5,  2,   6,  1,  0, 1};
      vecs[4] = '{0,   0,  -1, 25,  0,   0,  0,  -1,  0,  51,  0,  1, 1};
      vecs[5] = '{1,   1,  -1,  0,  1,   0,  0,   3,  2,   4,  1,  0, 0};
      vecs[6] = '{0,   0,  -1,  0,  1,   0,  0,   3,  2,   4,  1,  0, 0};
      vecs[7] = '{1,   2,  22,  4,  1,   0,  0,  11,  2,  12,  1,  0, 1};
      vecs[8] = '{0,   0,  -1,  0,  1,   1,  9,   3,  2,   4,  1,  0, 9};
      tail    = '{0,   0,  -1,  0,  0,   0,  0,   3,  3,   4,  0,  0, 9};

      rst = 1'b0;
      bif.pc_turn_State = 1'b0;
      bif.init = 1'b0;
      bif.ship_cells = '0;
      load_req = 1'b0;
      for (int i = 0; i < CELLS; i++) mem_init[i] = 2'b00;
      repeat (2) @(negedge clk);

      // Reset state.
      chk("rst board_we", int'(bif.board_we), 0);
      chk("rst pc_move", int'(bif.pc_move), 0);
      chk("rst hit", int'(bif.hit), 0);
      chk("rst no_target", int'(bif.no_target), 0);
      chk("rst player_ships", int'(bif.player_ships), 0);
      chk("rst board_addr", int'(bif.board_addr), 0);
      chk("rst lfsr", int'(dut.u_lfsr.q_q), 8'hA5);
      rst = 1'b1;
      @(negedge clk);

      // Reset asserted while WRITE is in progress.
      bif.ship_cells = 5'd5;
      bif.init = 1'b1;
      @(negedge clk);
      bif.init = 1'b0;
      c = cand_of(next_l(tb_lfsr));
      preset(c, 0, 0);
      load_req = 1'b1;
      bif.pc_turn_State = 1'b1;
      seen = -1;
      for (k = 0; k < 10 && seen < 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         load_req = 1'b0;
         if (bif.board_we) seen = k;
      end
      chk("midwrite we_edge", seen, 3);
      chk("midwrite ships_before", int'(bif.player_ships), 5);
      rst = 1'b0;
      #1;
      chk("midwrite rst board_we", int'(bif.board_we), 0);
      chk("midwrite rst pc_move", int'(bif.pc_move), 0);
      chk("midwrite rst player_ships", int'(bif.player_ships), 0);
      bif.pc_turn_State = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("release lfsr", int'(dut.u_lfsr.q_q), 8'hA5);
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (bif.pc_move || bif.board_we) cnt++;
      end
      chk("after reset quiet", cnt, 0);

      // Table of full turns.
      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Abort during READ, then a normal turn.
      bif.pc_turn_State = 1'b1;
      @(posedge clk); @(negedge clk);   // edge 0 -> PICK
      @(posedge clk); @(negedge clk);   // edge 1 -> READ
      bif.pc_turn_State = 1'b0;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (bif.pc_move || bif.board_we) cnt++;
      end
      chk("abort quiet", cnt, 0);
      chk("abort ships", int'(bif.player_ships), 9);
      run_vec(9, tail);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
